// File: rtl/dtack_term_sync_if.sv
// dtack_term_sync_if: async 68000 strobes in, cycle termination and status out
interface dtack_term_sync_if;
  logic       as_n;
  logic       dtack_dly_n;
  logic       term_n;
  logic       berr_n;
  logic       busy;
  logic [7:0] waits;
  modport master (output as_n, dtack_dly_n, input term_n, berr_n, busy, waits);
  modport slave  (input as_n, dtack_dly_n, output term_n, berr_n, busy, waits);
endinterface

// File: rtl/dtack_term_sync.sv
// dtack_term_sync: syncs AS/DTACK into CLKCPU, one TERM_N strobe per AS cycle; BUS_TIMEOUT_EN adds bus-error timeout
module dtack_term_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int TERM_CYCLES = 1,
  parameter int TIMEOUT     = 200
) (
  input logic              i_clkcpu,
  input logic              i_reset_n,
  dtack_term_sync_if.slave bus
);
`ifdef BUS_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, WAIT, TERM, RELEASE, BERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, WAIT, TERM, RELEASE} state_t;
`endif
  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_as_sync;
  logic [SYNC_STAGES-1:0] r_dtk_sync;
  logic [7:0]             r_cnt;
  logic [7:0]             r_waits;
  logic [3:0]             r_tcnt;
  logic                   r_term_n;
  logic                   r_busy;
  logic                   w_as_s;
  logic                   w_dtk_s;
  logic [7:0]             w_cnt_inc;
  if (SYNC_STAGES < 2 || TERM_CYCLES < 1 || TERM_CYCLES > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_params
    $error("dtack_term_sync: parameter out of range");
  end
  assign w_as_s    = r_as_sync[SYNC_STAGES-1];
  assign w_dtk_s   = r_dtk_sync[SYNC_STAGES-1];
  assign w_cnt_inc = (r_cnt == 8'hFF) ? 8'hFF : r_cnt + 8'd1;
  assign bus.term_n = r_term_n;
  assign bus.busy   = r_busy;
  assign bus.waits  = r_waits;
`ifdef BUS_TIMEOUT_EN
  logic r_berr_n;
  assign bus.berr_n = r_berr_n;
`else
  assign bus.berr_n = 1'b1;
`endif
  // shift both async strobes through their synchroniser chains; idle-high on reset
  always_ff @(posedge i_clkcpu) begin
    if (!i_reset_n) begin
      r_as_sync  <= '1;
      r_dtk_sync <= '1;
    end else begin
      r_as_sync  <= {r_as_sync[SYNC_STAGES-2:0], bus.as_n};
      r_dtk_sync <= {r_dtk_sync[SYNC_STAGES-2:0], bus.dtack_dly_n};
    end
  end
  // per-AS-cycle FSM with registered strobe, status and wait count
  always_ff @(posedge i_clkcpu) begin
    if (!i_reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_tcnt   <= '0;
      r_term_n <= 1'b1;
      r_busy   <= 1'b0;
      r_waits  <= '0;
`ifdef BUS_TIMEOUT_EN
      r_berr_n <= 1'b1;
`endif
    end else begin
      case (r_state)
        IDLE: if (!w_as_s) begin
          r_state <= WAIT;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
        WAIT: begin
          r_cnt <= w_cnt_inc;
          if (w_as_s) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (!w_dtk_s) begin
            r_state  <= TERM;
            r_term_n <= 1'b0;
            r_waits  <= w_cnt_inc;
            r_tcnt   <= '0;
          end
`ifdef BUS_TIMEOUT_EN
          else if (r_cnt == 8'(TIMEOUT)) begin
            r_state  <= BERR;
            r_berr_n <= 1'b0;
            r_waits  <= 8'hFF;
          end
`endif
        end
        TERM: if (r_tcnt == 4'(TERM_CYCLES - 1)) begin
          r_state  <= RELEASE;
          r_term_n <= 1'b1;
        end else begin
          r_tcnt <= r_tcnt + 4'd1;
        end
        RELEASE: if (w_as_s && w_dtk_s) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
`ifdef BUS_TIMEOUT_EN
        BERR: if (w_as_s) begin
          r_state  <= IDLE;
          r_berr_n <= 1'b1;
          r_busy   <= 1'b0;
        end
`endif
        default: begin
          r_state  <= IDLE;
          r_term_n <= 1'b1;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dtack_term_sync.sv
// tb_dtack_term_sync: table vectors, randomized run against a flag-based model, long-cycle corner cases
module tb_dtack_term_sync;
  localparam int SYNC = 2;
  localparam int TC   = 1;
  localparam int TO   = 10;
`ifdef BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  typedef struct {
    logic r, a, d;
    int   n;
    logic t, y;
    int   w;
  } vec_t;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;
  logic m_aq[$];
  logic m_dq[$];
  bit   m_act, m_ack, m_err;
  int   m_tl, m_n, m_waits;
  vec_t tbl[$];
  dtack_term_sync_if bus ();
  dtack_term_sync #(.SYNC_STAGES(SYNC), .TERM_CYCLES(TC), .TIMEOUT(TO)) dut (
    .i_clkcpu (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  // Model: an AS cycle is "active" until released; inside it the cycle is either
  // still waiting, acknowledged (strobe time left / released), or errored.
  task automatic model_step();
    logic a, d;
    if (!rst_n) begin
      m_aq.delete();
      m_dq.delete();
      repeat (SYNC) begin
        m_aq.push_back(1'b1);
        m_dq.push_back(1'b1);
      end
      m_act = 0; m_ack = 0; m_err = 0; m_tl = 0; m_n = 0; m_waits = 0;
      return;
    end
    a = m_aq[$];
    d = m_dq[$];
    m_aq.push_front(bus.as_n);
    void'(m_aq.pop_back());
    m_dq.push_front(bus.dtack_dly_n);
    void'(m_dq.pop_back());
    if (!m_act) begin
      if (!a) begin m_act = 1; m_ack = 0; m_n = 0; end
    end else if (m_tl > 0) m_tl--;
    else if (m_err) begin
      if (a) begin m_act = 0; m_err = 0; end
    end else if (m_ack) begin
      if (a && d) m_act = 0;
    end else begin
      m_n++;
      if (a) m_act = 0;
      else if (!d) begin m_ack = 1; m_tl = TC; m_waits = (m_n > 255) ? 255 : m_n; end
      else if (TO_EN && m_n - 1 == TO) begin m_err = 1; m_waits = 255; end
    end
  endtask
  function automatic logic [31:0] obs();
    return {21'd0, bus.term_n, bus.berr_n, bus.busy, bus.waits};
  endfunction
  function automatic logic [31:0] mdl();
    return {21'd0, m_tl == 0, !m_err, m_act, 8'(m_waits)};
  endfunction
  task automatic cyc(input logic r, input logic a, input logic d);
    rst_n = r;
    bus.as_n = a;
    bus.dtack_dly_n = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask
  initial begin
    logic a, d;
    int   pa, pd, n, bad;
    n_vec = 0;
    n_bad = 0;
    // r a d cycles | term_n busy waits
    tbl.push_back('{1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b1, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 5, 1'b1, 1'b1, 1});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b1, 1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 4, 1'b1, 1'b1, 1});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 2, 1'b1, 1'b1, 1});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 7, 1'b1, 1'b1, 1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b1, 7});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1, 7});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 3, 1'b1, 1'b0, 7});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 5, 1'b1, 1'b1, 7});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 2, 1'b1, 1'b1, 7});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b0, 7});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 3, 1'b1, 1'b0, 7});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 5, 1'b1, 1'b1, 7});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 0});
    foreach (tbl[i]) begin
      repeat (tbl[i].n) cyc(tbl[i].r, tbl[i].a, tbl[i].d);
      chk($sformatf("vec%0d", i), obs(), {21'd0, tbl[i].t, 1'b1, tbl[i].y, 8'(tbl[i].w)});
    end
    cyc(1'b0, 1'b1, 1'b1);
    a = 1'b1;
    d = 1'b1;
    pa = 8;
    pd = 8;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        pa = $urandom_range(2, 40);
        pd = $urandom_range(2, 40);
      end
      if ($urandom_range(1, pa) == 1) a = ~a;
      if ($urandom_range(1, pd) == 1) d = ~d;
      cyc($urandom_range(0, 299) != 0, a, d);
      chk("rand", obs(), mdl());
    end
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
`ifdef BUS_TIMEOUT_EN
    n = 0;
    do begin cyc(1'b1, 1'b0, 1'b1); n++; end while (bus.berr_n !== 1'b0 && n < 40);
    chk("berr_edges", n, SYNC + 2 + TO);
    chk("berr_state", obs(), {21'd0, 1'b1, 1'b0, 1'b1, 8'd255});
    repeat (5) cyc(1'b1, 1'b0, 1'b1);
    chk("berr_hold", obs(), {21'd0, 1'b1, 1'b0, 1'b1, 8'd255});
    repeat (SYNC + 1) cyc(1'b1, 1'b1, 1'b1);
    chk("berr_exit", obs(), {21'd0, 1'b1, 1'b1, 1'b0, 8'd255});
`else
    bad = 0;
    repeat (300) begin
      cyc(1'b1, 1'b0, 1'b1);
      if (bus.berr_n !== 1'b1) bad++;
    end
    chk("long_berr", bad, 0);
    chk("long_wait", obs(), {21'd0, 1'b1, 1'b1, 1'b1, 8'd0});
    n = 0;
    do begin cyc(1'b1, 1'b0, 1'b0); n++; end while (bus.term_n !== 1'b0 && n < 10);
    chk("long_lat", n, SYNC + 1);
    chk("long_term", obs(), {21'd0, 1'b0, 1'b1, 1'b1, 8'd255});
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
